// File: rtl/data_cache_pkg.sv
// Shared types, widths and helpers for the direct-mapped write-back data cache.
package data_cache_pkg;

  localparam int CPU_ADDR_W   = 8;
  localparam int LINE_INDEX_W = 3;
  localparam int BYTE_OFF_W   = 2;
  localparam int TAG_W        = CPU_ADDR_W - LINE_INDEX_W - BYTE_OFF_W;
  localparam int LINES        = 1 << LINE_INDEX_W;
  localparam int BLOCK_W      = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_e;

  // Pick byte 'off' out of a 4-byte line (byte 0 in the low bits).
  function automatic logic [7:0] byte_sel(input logic [BLOCK_W-1:0] blk,
                                          input logic [BYTE_OFF_W-1:0] off);
    return blk[8*off +: 8];
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Line storage: data and tags (not reset), valid and dirty (async clear).
// Two combinational read ports: 'a' follows the CPU index for hit
// detection, 'b' follows the latched miss index for write-back.
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int INDEX_W  = LINE_INDEX_W,
  parameter int OFFSET_W = BYTE_OFF_W,
  parameter int TW       = TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  a_idx,
  output logic [BLOCK_W-1:0]  a_data,
  output logic [TW-1:0]       a_tag,
  output logic                a_valid,
  output logic                a_dirty,
  input  logic [INDEX_W-1:0]  b_idx,
  output logic [BLOCK_W-1:0]  b_data,
  output logic [TW-1:0]       b_tag,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_idx,
  input  logic [OFFSET_W-1:0] wr_off,
  input  logic [7:0]          wr_byte,
  input  logic                fill_en,
  input  logic [INDEX_W-1:0]  fill_idx,
  input  logic [TW-1:0]       fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data
);

  localparam int N = 1 << INDEX_W;

  logic [N-1:0][BLOCK_W-1:0] data_q, data_d;
  logic [N-1:0][TW-1:0]      tag_q, tag_d;
  logic [N-1:0]              valid_q, valid_d;
  logic [N-1:0]              dirty_q, dirty_d;

  assign a_data  = data_q[a_idx];
  assign a_tag   = tag_q[a_idx];
  assign a_valid = valid_q[a_idx];
  assign a_dirty = dirty_q[a_idx];
  assign b_data  = data_q[b_idx];
  assign b_tag   = tag_q[b_idx];

  // Next-state of the arrays: a store byte-merges and dirties the line,
  // a fill replaces the whole line and leaves it clean.
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      data_d[wr_idx][8*wr_off +: 8] = wr_byte;
      dirty_d[wr_idx]               = 1'b1;
    end
    if (fill_en) begin
      data_d[fill_idx]  = fill_data;
      tag_d[fill_idx]   = fill_tag;
      valid_d[fill_idx] = 1'b1;
      dirty_d[fill_idx] = 1'b0;
    end
  end

  // Data and tag contents are meaningless until valid, so they carry no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  // Valid/dirty flags clear asynchronously so an interrupted fill leaves
  // the line invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete with
// no stall; misses run IDLE -> [WRITEBACK ->] FETCH -> IDLE and then replay
// as a hit. Miss index/tag are latched on leaving IDLE so the CPU address
// may wander while the miss is in flight.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int INDEX_W  = LINE_INDEX_W,
  parameter int OFFSET_W = BYTE_OFF_W,
  parameter int ADDR_W   = CPU_ADDR_W
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [7:0]                 WRITEDATA,
  output logic [7:0]                 READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]         MEM_READDATA,
  input  logic                       MEM_BUSYWAIT
);

  localparam int TW = ADDR_W - INDEX_W - OFFSET_W;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] miss_idx_q, miss_idx_d;
  logic [TW-1:0]      miss_tag_q, miss_tag_d;

  logic [TW-1:0]       req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;

  logic [BLOCK_W-1:0] a_data, b_data;
  logic [TW-1:0]      a_tag, b_tag;
  logic               a_valid, a_dirty;
  logic               hit, req;
  logic               wr_en, fill_en;

  assign req_tag = ADDRESS[ADDR_W-1 -: TW];
  assign req_idx = ADDRESS[OFFSET_W +: INDEX_W];
  assign req_off = ADDRESS[OFFSET_W-1:0];

  assign req = READ || WRITE;
  assign hit = a_valid && (a_tag == req_tag);

  data_cache_array #(
    .INDEX_W (INDEX_W),
    .OFFSET_W(OFFSET_W),
    .TW      (TW)
  ) u_array (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .a_idx    (req_idx),
    .a_data   (a_data),
    .a_tag    (a_tag),
    .a_valid  (a_valid),
    .a_dirty  (a_dirty),
    .b_idx    (miss_idx_q),
    .b_data   (b_data),
    .b_tag    (b_tag),
    .wr_en    (wr_en),
    .wr_idx   (req_idx),
    .wr_off   (req_off),
    .wr_byte  (WRITEDATA),
    .fill_en  (fill_en),
    .fill_idx (miss_idx_q),
    .fill_tag (miss_tag_q),
    .fill_data(MEM_READDATA)
  );

  // Next state, miss latching, array strobes and Moore memory-side outputs.
  // A store is only committed from IDLE on a hit; a miss that loses its
  // request mid-flight still completes the fill but applies no store.
  always_comb begin
    state_d       = state_q;
    miss_idx_d    = miss_idx_q;
    miss_tag_d    = miss_tag_q;
    wr_en         = 1'b0;
    fill_en       = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            wr_en = WRITE;
          end else begin
            miss_idx_d = req_idx;
            miss_tag_d = req_tag;
            state_d    = (a_valid && a_dirty) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {b_tag, miss_idx_q};
        MEM_WRITEDATA = b_data;
        if (!MEM_BUSYWAIT) state_d = FETCH;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {miss_tag_q, miss_idx_q};
        if (!MEM_BUSYWAIT) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // CPU-side outputs: load data only when a hit is being served from IDLE.
  always_comb begin
    BUSYWAIT = (state_q != IDLE) || (req && !hit);
    READDATA = ((state_q == IDLE) && hit) ? byte_sel(a_data, req_off) : 8'h00;
  end

  // FSM state and latched miss coordinates.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: block memory with fixed latency, a byte-level golden
// memory for load values, and an abstract line-state model for stall length.
module tb_data_cache;

  localparam int L = 5;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  always #5 CLK = ~CLK;

  data_cache dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .READ         (READ),
    .WRITE        (WRITE),
    .ADDRESS      (ADDRESS),
    .WRITEDATA    (WRITEDATA),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  // ---------------- block memory, latency L ----------------
  logic [31:0] mem [64];
  int          mcnt = 0;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt < L - 1);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (MEM_READ || MEM_WRITE) begin
      if (!MEM_BUSYWAIT) begin
        if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
        mcnt <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] gold [256];
  bit         mv [8];
  logic [2:0] mt [8];
  bit         md [8];

  int tests = 0;
  int fails = 0;

  // observations from the last access
  int          stall;
  logic [7:0]  rdata;
  bit          saw_wr, saw_rd, wr_first;
  logic [5:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;

  function automatic int exp_stall(input logic [7:0] a);
    logic [2:0] i;
    i = a[4:2];
    if (mv[i] && mt[i] == a[7:5]) return 0;
    if (mv[i] && md[i]) return 2 * L + 1;
    return L + 1;
  endfunction

  task automatic model_update(input bit wr, input logic [7:0] a, input logic [7:0] d);
    logic [2:0] i;
    bit h;
    i = a[4:2];
    h = mv[i] && mt[i] == a[7:5];
    mv[i] = 1'b1;
    mt[i] = a[7:5];
    md[i] = wr ? 1'b1 : (h ? md[i] : 1'b0);
    if (wr) gold[a] = d;
  endtask

  // Drive one request starting at posedge+1; returns at posedge+1 after
  // the edge that completes it.
  task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    bit done;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    stall = 0; saw_wr = 0; saw_rd = 0; wr_first = 0; done = 0; rdata = 8'h00;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge CLK);
      if (MEM_WRITE && !saw_wr) begin
        saw_wr = 1; wr_addr = MEM_ADDRESS; wr_data = MEM_WRITEDATA;
        if (!saw_rd) wr_first = 1;
      end
      if (MEM_READ && !saw_rd) begin saw_rd = 1; rd_addr = MEM_ADDRESS; end
      if (!BUSYWAIT) begin rdata = READDATA; done = 1; end
      else stall++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL access_timeout addr=%02h still busy after 100 cycles", a);
    end
    @(posedge CLK); #1;
    READ = 0; WRITE = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit seen;
    repeat (2) @(posedge CLK);
    #1;
    tests++;
    if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
      fails++; $display("FAIL reset_strobes got %b exp 000", {BUSYWAIT, MEM_READ, MEM_WRITE});
    end
    tests++;
    if ({READDATA, MEM_ADDRESS, MEM_WRITEDATA} !== 46'h0) begin
      fails++; $display("FAIL reset_data got rd=%02h ma=%02h mwd=%08h exp 0", READDATA, MEM_ADDRESS, MEM_WRITEDATA);
    end
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    READ = 1; ADDRESS = 8'h00;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (MEM_READ) seen = 1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL reset_fetch_start got no MEM_READ exp MEM_READ=1"); end
    @(negedge CLK); #2;
    RESET_N = 1'b0; READ = 0;
    #1;
    tests++;
    if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
      fails++; $display("FAIL reset_mid_fetch got %b exp 000", {BUSYWAIT, MEM_READ, MEM_WRITE});
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    access(1, 0, 8'h00, 8'h00);
    tests++;
    if (stall !== L + 1) begin fails++; $display("FAIL reset_remiss_stall got %0d exp %0d", stall, L + 1); end
    tests++;
    if (rdata !== gold[0]) begin fails++; $display("FAIL reset_remiss_data got %02h exp %02h", rdata, gold[0]); end
    model_update(0, 8'h00, 8'h00);
  endtask

  task automatic test_clean_read_miss();
    access(1, 0, 8'h25, 8'h00);
    tests++;
    if (!(saw_rd && !saw_wr && rd_addr === 6'h09)) begin
      fails++; $display("FAIL clean_miss_addr got rd=%0b wr=%0b addr=%02h exp rd=1 wr=0 addr=09", saw_rd, saw_wr, rd_addr);
    end
    tests++;
    if (rdata !== 8'hBB) begin fails++; $display("FAIL clean_miss_data got %02h exp bb", rdata); end
    tests++;
    if (stall !== 6) begin fails++; $display("FAIL clean_miss_stall got %0d exp 6", stall); end
    model_update(0, 8'h25, 8'h00);
  endtask

  task automatic test_write_hit();
    access(0, 1, 8'h26, 8'h5A);
    tests++;
    if (stall !== 0) begin fails++; $display("FAIL write_hit_stall got %0d exp 0", stall); end
    model_update(1, 8'h26, 8'h5A);
    access(1, 0, 8'h26, 8'h00);
    tests++;
    if (rdata !== 8'h5A || stall !== 0) begin
      fails++; $display("FAIL write_hit_readback got %02h/%0d exp 5a/0", rdata, stall);
    end
  endtask

  task automatic test_dirty_miss();
    access(1, 0, 8'h46, 8'h00);
    tests++;
    if (!(saw_wr && wr_first && wr_addr === 6'h09 && wr_data === 32'hDD5ABBAA)) begin
      fails++; $display("FAIL dirty_wb got wr=%0b first=%0b addr=%02h data=%08h exp 1 1 09 dd5abbaa", saw_wr, wr_first, wr_addr, wr_data);
    end
    tests++;
    if (!(saw_rd && rd_addr === 6'h11)) begin
      fails++; $display("FAIL dirty_fetch got rd=%0b addr=%02h exp 1 11", saw_rd, rd_addr);
    end
    tests++;
    if (stall !== 11) begin fails++; $display("FAIL dirty_stall got %0d exp 11", stall); end
    tests++;
    if (rdata !== gold[8'h46]) begin fails++; $display("FAIL dirty_data got %02h exp %02h", rdata, gold[8'h46]); end
    tests++;
    if (mem[9] !== 32'hDD5ABBAA) begin fails++; $display("FAIL dirty_mem got %08h exp dd5abbaa", mem[9]); end
    model_update(0, 8'h46, 8'h00);
  endtask

  task automatic test_write_allocate();
    int e;
    e = exp_stall(8'h83);
    access(0, 1, 8'h83, 8'h77);
    tests++;
    if (stall !== e || !saw_rd || rd_addr !== 6'h20) begin
      fails++; $display("FAIL alloc_miss got stall=%0d addr=%02h exp %0d 20", stall, rd_addr, e);
    end
    model_update(1, 8'h83, 8'h77);
    access(1, 0, 8'h83, 8'h00);
    tests++;
    if (rdata !== 8'h77 || stall !== 0) begin
      fails++; $display("FAIL alloc_readback got %02h/%0d exp 77/0", rdata, stall);
    end
    access(1, 0, 8'h03, 8'h00);
    tests++;
    if (stall !== 11 || wr_addr !== 6'h20 || wr_data[31:24] !== 8'h77) begin
      fails++; $display("FAIL alloc_dirty got stall=%0d wa=%02h wb3=%02h exp 11 20 77", stall, wr_addr, wr_data[31:24]);
    end
    tests++;
    if (rdata !== gold[8'h03]) begin fails++; $display("FAIL alloc_evict_data got %02h exp %02h", rdata, gold[8'h03]); end
    model_update(0, 8'h03, 8'h00);
  endtask

  task automatic test_request_drop();
    bit seen, idle;
    READ = 1; ADDRESS = 8'h50;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (MEM_READ) seen = 1;
    end
    READ = 0;
    idle = 0;
    for (int c = 0; c < 20 && !idle; c++) begin
      @(negedge CLK);
      if (!BUSYWAIT) idle = 1;
    end
    tests++;
    if (!(seen && idle)) begin fails++; $display("FAIL drop_complete got fetch=%0b idle=%0b exp 1 1", seen, idle); end
    @(posedge CLK); #1;
    model_update(0, 8'h50, 8'h00);
    access(1, 0, 8'h50, 8'h00);
    tests++;
    if (stall !== 0 || rdata !== gold[8'h50]) begin
      fails++; $display("FAIL drop_rehit got %02h/%0d exp %02h/0", rdata, stall, gold[8'h50]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      int op, e;
      bit rd, wr;
      logic [7:0] a, d, g;
      op = $urandom_range(0, 3);
      rd = (op != 2);
      wr = (op >= 2);
      a  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      d  = 8'($urandom);
      e  = exp_stall(a);
      g  = gold[a];
      access(rd, wr, a, d);
      tests++;
      if (stall !== e) begin fails++; $display("FAIL rand_stall n=%0d addr=%02h got %0d exp %0d", n, a, stall, e); end
      if (!wr) begin
        tests++;
        if (rdata !== g) begin fails++; $display("FAIL rand_data n=%0d addr=%02h got %02h exp %02h", n, a, rdata, g); end
      end
      model_update(wr, a, d);
    end
  endtask

  // Back-to-back stores to one line with no idle cycle between, then loads.
  task automatic test_back_to_back();
    access(1, 0, 8'hE0, 8'h00);
    model_update(0, 8'hE0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      access(0, 1, 8'(8'hE0 + k), 8'(8'h10 * k + 1));
      tests++;
      if (stall !== 0) begin fails++; $display("FAIL b2b_store_stall k=%0d got %0d exp 0", k, stall); end
      model_update(1, 8'(8'hE0 + k), 8'(8'h10 * k + 1));
    end
    for (int k = 0; k < 4; k++) begin
      access(1, 0, 8'(8'hE0 + k), 8'h00);
      tests++;
      if (rdata !== 8'(8'h10 * k + 1)) begin
        fails++; $display("FAIL b2b_load k=%0d got %02h exp %02h", k, rdata, 8'(8'h10 * k + 1));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[9] = 32'hDDCCBBAA;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = mem[i >> 2];
      gold[i] = w[8*(i % 4) +: 8];
    end
    for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; mt[i] = 3'd0; end
    test_reset();
    test_clean_read_miss();
    test_write_hit();
    test_dirty_miss();
    test_write_allocate();
    test_request_drop();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU datapath and the 32-bit-block data memory. It consumes the control unit's `READ`/`WRITE` strobes, the ALU result as the byte address, and register-file data for stores. It returns load data and holds `BUSYWAIT` high to stall the PC and register file while a miss is serviced. It is the stage directly downstream of the control unit on the load/store path.

## Interface
- `INDEX_W`, default 3: index bits; the cache has 2**INDEX_W lines.
- `OFFSET_W`, default 2: byte-offset bits; a line holds 4 bytes (one memory block).
- `ADDR_W`, default 8: CPU byte-address width. Tag width is ADDR_W−INDEX_W−OFFSET_W = 3.

Ports:
- `CLK` in 1: the only clock. All state updates on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `READ` in 1: load request from the control unit.
- `WRITE` in 1: store request from the control unit.
- `ADDRESS` in 8: byte address (ALU result).
- `WRITEDATA` in 8: store data.
- `READDATA` out 8: load data.
- `BUSYWAIT` out 1: CPU stall.
- `MEM_READ` out 1: block-read strobe to data memory.
- `MEM_WRITE` out 1: block-write strobe to data memory.
- `MEM_ADDRESS` out 6: block address {tag, index}.
- `MEM_WRITEDATA` out 32: block being written back.
- `MEM_READDATA` in 32: block returned by memory.
- `MEM_BUSYWAIT` in 1: memory busy; the transfer completes on the first rising edge where this is 0 while a strobe is held.

## Operation
- Address split: tag = ADDRESS[7:5], index = ADDRESS[4:2], offset = ADDRESS[1:0]. Byte `offset` of a line sits at bits [8*offset+7 : 8*offset].
- Per line: 32-bit data, 3-bit tag, valid bit, dirty bit.
- hit = valid[index] && tag[index] == tag.
- FSM states: IDLE, WRITEBACK, FETCH.
  - IDLE → IDLE: no request, or request hits.
  - IDLE → WRITEBACK: request misses and the line is dirty.
  - IDLE → FETCH: request misses and the line is clean or invalid.
  - WRITEBACK → FETCH: on the edge where MEM_BUSYWAIT=0.
  - FETCH → IDLE: on the edge where MEM_BUSYWAIT=0. On that same edge the line is loaded with MEM_READDATA, the new tag, valid=1 and dirty=0.
- Read hit: READDATA = the selected byte (combinational). No stall.
- Write hit: on the next edge, the byte is written at the offset and dirty is set to 1. No stall.
- Miss: after the fill, the FSM returns to IDLE, the request is re-evaluated and hits, and the read or write hit path completes it.
- Moore outputs:
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={old tag, index}, MEM_WRITEDATA = old line.
  - FETCH: MEM_READ=1, MEM_ADDRESS={tag, index}.
  - IDLE: both strobes 0.
- BUSYWAIT = (state ≠ IDLE) || ((READ||WRITE) && !hit).
- Once a miss has started, the transaction finishes even if READ/WRITE deassert. The line is filled; no CPU write is applied.
- READ and WRITE both high is treated as WRITE. READDATA is don't-care in that case.
- MEM_ADDRESS and the index/tag used by the FSM are latched on the IDLE exit edge, so a changing ADDRESS does not affect an in-flight miss.

## Timing
- Reset (RESET_N=0, asynchronous):
  - All valid and dirty bits = 0; state = IDLE.
  - READDATA = 0, BUSYWAIT = 0, MEM_READ = 0, MEM_WRITE = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0.
  - Line data and tags are not reset.
- Reset mid-miss: the strobes drop immediately, the target line stays invalid, and no fill occurs.
- Hit latency: 0 cycles for a read (same cycle); a write commits at the next edge.
- Clean miss: BUSYWAIT rises in the same cycle as the request. 1 edge to enter FETCH, then L memory cycles, then 1 cycle in IDLE serving the hit. Stall = L+1 cycles.
- Dirty miss: stall = 2L+1 cycles.
- MEM_BUSYWAIT is sampled only on rising edges; glitches between edges are ignored.
- Strobes are held stable for the whole transfer and never overlap.

## Structure
- Shared package `data_cache_pkg`:
  - state enum (IDLE, WRITEBACK, FETCH);
  - derived widths TAG_W, LINES, BLOCK_W = 32;
  - byte-select helper function.
- Sub-module `data_cache_array`: storage for data, tag, valid and dirty.
  - Combinational read port.
  - Synchronous byte-write port and full-line fill port.
  - Asynchronous clear of valid/dirty.
- The top level holds the FSM, the hit compare and the output muxing.

## Test plan
Memory model: L = 5 cycles.
- **Reset**: assert RESET_N=0 mid-FETCH → strobes drop within the cycle. After release, READ at 0x00 misses again.
- **Clean read miss**: READ at 0x25 after reset → MEM_READ=1 with MEM_ADDRESS=0x09. Return MEM_READDATA=0xDDCCBBAA → READDATA=0xBB, with BUSYWAIT high for 6 cycles.
- **Write hit**: WRITE 0x5A at 0x26 after the fill above → no stall. READ at 0x26 returns 0x5A and the line is dirty.
- **Dirty miss**: READ at 0x46 (same index, tag 2) → MEM_WRITE first with MEM_ADDRESS=0x09 and MEM_WRITEDATA=0xDD5ABBAA, then MEM_READ with MEM_ADDRESS=0x11. Stall = 11 cycles.
- **Write-allocate**: WRITE 0x77 at 0x83 (miss) → line fetched. Byte 3 becomes 0x77, dirty=1, and a subsequent READ at 0x83 returns 0x77.
- **Request drop**: deassert READ during FETCH → the fill still completes and BUSYWAIT clears. A later READ to the same line hits with 0 stall.
